// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word, RAM handshake state, and the
// arbiter's state and grant-source encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Grant source: dclass=1 for data, 0 for instruction; core selects 0/1.
  typedef struct packed {
    logic dclass;
    logic core;
  } arb_src_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. When both inputs request, the
// pointer names the winner; otherwise the single requester wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       sel
);

  // Pick the winner for this class
  always_comb begin
    valid = |req;
    if (&req) begin
      sel = ptr;
    end else begin
      sel = req[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single RAM port between the instruction
// and data requesters of two cores. Data wins over instruction, same-class
// requesters alternate round-robin, and a starvation counter forces an
// instruction grant after STARVE_MAX consecutive data grants while an
// instruction request waits.
// Optional build macro ARB_GRANT_STATS_EN adds per-source completed-grant
// counters (grant_cnt) with a synchronous clear (stats_clr).
module ram_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [1:0]      iREN,
  input  word_t [1:0]     iaddr,
  input  logic [1:0]      dREN,
  input  logic [1:0]      dWEN,
  input  word_t [1:0]     daddr,
  input  word_t [1:0]     dstore,
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic [1:0]      iwait,
  output logic [1:0]      dwait,
  output word_t [1:0]     iload,
  output word_t [1:0]     dload,
  output logic [1:0]      gnt_src,
`ifdef ARB_GRANT_STATS_EN
  input  logic            stats_clr,
  output logic [3:0][15:0] grant_cnt,
`endif
  output logic            gnt_valid,
  output logic            ram_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  arb_src_t   gnt;
  logic       ptr_i;
  logic       ptr_d;
  logic [3:0] starve_cnt;

  logic [1:0] dreq;
  logic       i_valid;
  logic       i_sel;
  logic       d_valid;
  logic       d_sel;
  logic       starved;
  logic       take_d;
  logic       take_i;
  logic       in_grant;
  logic       req_held;
  logic       active;
  logic       done;
  logic       err_hit;

  assign dreq = dREN | dWEN;

  rr_pick2 u_pick_i (
    .req   (iREN),
    .ptr   (ptr_i),
    .valid (i_valid),
    .sel   (i_sel)
  );

  rr_pick2 u_pick_d (
    .req   (dreq),
    .ptr   (ptr_d),
    .valid (d_valid),
    .sel   (d_sel)
  );

  // Class selection and grant-cycle status
  always_comb begin
    starved  = i_valid && (starve_cnt == STARVE_LIM);
    take_d   = d_valid && !starved;
    take_i   = !take_d && i_valid;
    in_grant = (state == ARB_GRANT);
    req_held = gnt.dclass ? dreq[gnt.core] : iREN[gnt.core];
    active   = in_grant && req_held;
    done     = active && (ramstate == ACCESS);
    err_hit  = active && (ramstate == ERROR);
  end

  // Arbitration state, grant register, round-robin pointers, starvation
  // counter and sticky RAM error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      ptr_i      <= 1'b0;
      ptr_d      <= 1'b0;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (take_d) begin
        state      <= ARB_GRANT;
        gnt.dclass <= 1'b1;
        gnt.core   <= d_sel;
        ptr_d      <= ~d_sel;
        if (i_valid) begin
          if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end else begin
          starve_cnt <= '0;
        end
      end else if (take_i) begin
        state      <= ARB_GRANT;
        gnt.dclass <= 1'b0;
        gnt.core   <= i_sel;
        ptr_i      <= ~i_sel;
        starve_cnt <= '0;
      end
    end else begin
      // Leave GRANT on completion, error, or the requester withdrawing;
      // FREE/BUSY hold the grant.
      if (!req_held || done || err_hit) begin
        state <= ARB_IDLE;
      end
      if (err_hit) begin
        ram_err <= 1'b1;
      end
    end
  end

  // RAM port and requester-side outputs, driven only while the granted
  // requester still holds its request
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (active) begin
      if (gnt.dclass) begin
        ramaddr = daddr[gnt.core];
        if (dWEN[gnt.core]) begin
          ramWEN   = 1'b1;
          ramstore = dstore[gnt.core];
        end else begin
          ramREN = 1'b1;
        end
        if (ramstate == ACCESS) begin
          dwait[gnt.core] = 1'b0;
          if (!dWEN[gnt.core]) begin
            dload[gnt.core] = ramload;
          end
        end
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt.core];
        if (ramstate == ACCESS) begin
          iwait[gnt.core] = 1'b0;
          iload[gnt.core] = ramload;
        end
      end
    end
  end

  // Grant visibility
  always_comb begin
    gnt_valid = in_grant;
    gnt_src   = in_grant ? gnt : '0;
  end

`ifdef ARB_GRANT_STATS_EN
  // Completed-grant counters indexed {dclass, core}: i0, i1, d0, d1
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else if (done && (grant_cnt[{gnt.dclass, gnt.core}] != 16'hFFFF)) begin
      grant_cnt[{gnt.dclass, gnt.core}] <= grant_cnt[{gnt.dclass, gnt.core}] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a small RAM model with
// configurable latency/error injection, and a scoreboard of expected
// completed transfers checked whenever the RAM reports ACCESS.
module tb_ram_port_arbiter;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic [1:0] iREN;
  word_t [1:0] iaddr;
  logic [1:0] dREN;
  logic [1:0] dWEN;
  word_t [1:0] daddr;
  word_t [1:0] dstore;
  ramstate_t  ramstate;
  word_t      ramload;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  logic [1:0] iwait;
  logic [1:0] dwait;
  word_t [1:0] iload;
  word_t [1:0] dload;
  logic [1:0] gnt_src;
  logic       gnt_valid;
  logic       ram_err;
`ifdef ARB_GRANT_STATS_EN
  logic             stats_clr;
  logic [3:0][15:0] grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] src;
    logic       we;
    word_t      addr;
    word_t      data;
  } exp_t;

  exp_t sb[$];

  ram_port_arbiter #(.STARVE_MAX(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .iwait     (iwait),
    .dwait     (dwait),
    .iload     (iload),
    .dload     (dload),
    .gnt_src   (gnt_src),
`ifdef ARB_GRANT_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .gnt_valid (gnt_valid),
    .ram_err   (ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: BUSY for 'lat' cycles then ACCESS; ERROR while err_arm set
  int unsigned busy_cnt;
  int unsigned lat;
  logic        err_arm;

  always_comb begin
    if (!(ramREN || ramWEN))    ramstate = FREE;
    else if (err_arm)           ramstate = ERROR;
    else if (busy_cnt >= lat)   ramstate = ACCESS;
    else                        ramstate = BUSY;
    ramload = (ramaddr == 32'h100) ? 32'hDEADBEEF : {ramaddr[15:0], 16'hC0DE};
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST)                  busy_cnt <= 0;
    else if (ramstate == BUSY)  busy_cnt <= busy_cnt + 1;
    else                        busy_cnt <= 0;
  end

  // Scoreboard monitor: every ACCESS cycle of a grant retires one expectation
  exp_t       e_m;
  logic [3:0] w_m;
  word_t      d_m;
  always @(negedge CLK) begin
    if (nRST && gnt_valid && ramstate == ACCESS) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got src=%b we=%b addr=%h, required no transfer",
                 gnt_src, ramWEN, ramaddr);
      end else begin
        e_m = sb.pop_front();
        w_m = 4'b1111;
        w_m[e_m.src] = 1'b0;
        d_m = e_m.we ? ramstore : (e_m.src[1] ? dload[e_m.src[0]] : iload[e_m.src[0]]);
        if ({gnt_src, ramWEN, ramREN, ramaddr, d_m, dwait, iwait} !==
            {e_m.src, e_m.we, ~e_m.we, e_m.addr, e_m.data, w_m}) begin
          errors++;
          $display("FAIL sb_xfer: got src=%b wen=%b ren=%b addr=%h data=%h waits=%b, required src=%b wen=%b ren=%b addr=%h data=%h waits=%b",
                   gnt_src, ramWEN, ramREN, ramaddr, d_m, {dwait, iwait},
                   e_m.src, e_m.we, ~e_m.we, e_m.addr, e_m.data, w_m);
        end
      end
    end
  end

  task automatic clear_reqs();
    iREN = '0; dREN = '0; dWEN = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_reqs();
    err_arm = 1'b0;
    lat = 0;
    sb.delete();
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    lat = 100; err_arm = 1'b0;
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
    iaddr[0] = 32'h10; iaddr[1] = 32'h14; daddr[0] = 32'h20; daddr[1] = 32'h24;
    dstore[0] = 32'h1; dstore[1] = 32'h2;
    @(negedge CLK);
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, gnt_valid, gnt_src, ram_err, ramaddr} !== {4'b1111, 6'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got iw=%b dw=%b ren=%b wen=%b gv=%b src=%b err=%b addr=%h, required 11 11 0 0 0 00 0 0",
               iwait, dwait, ramREN, ramWEN, gnt_valid, gnt_src, ram_err, ramaddr);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({gnt_valid, ramREN, ramWEN, iwait, dwait} !== {3'b000, 4'b1111}) begin
      errors++;
      $display("FAIL reset_release_idle: got gv=%b ren=%b wen=%b iw=%b dw=%b, required 0 0 0 11 11",
               gnt_valid, ramREN, ramWEN, iwait, dwait);
    end
    @(posedge CLK); #1;
    checks++;
    if ({gnt_valid, gnt_src, ramWEN, ramREN, ramaddr, ramstore} !== {1'b1, 2'b10, 1'b1, 1'b0, 32'h20, 32'h1}) begin
      errors++;
      $display("FAIL reset_first_grant: got gv=%b src=%b wen=%b ren=%b addr=%h st=%h, required 1 10 1 0 00000020 00000001",
               gnt_valid, gnt_src, ramWEN, ramREN, ramaddr, ramstore);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({ramREN, ramWEN, gnt_valid, dwait, iwait} !== {3'b000, 4'b1111}) begin
      errors++;
      $display("FAIL reset_mid_grant: got ren=%b wen=%b gv=%b dw=%b iw=%b, required 0 0 0 11 11",
               ramREN, ramWEN, gnt_valid, dwait, iwait);
    end
    clear_reqs();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    int unsigned ren_cycles;
    logic [33:0] got;
    logic [33:0] want;
    do_reset();
    lat = 2;
    iaddr[0] = 32'h100;
    iREN = 2'b01;
    sb.push_back('{src: 2'b00, we: 1'b0, addr: 32'h100, data: 32'hDEADBEEF});
    ren_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (ramREN) ren_cycles++;
      got  = {ramREN, iwait[0], iload[0]};
      want = {(i >= 1 && i <= 3), (i != 3), (i == 3) ? 32'hDEADBEEF : 32'h0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ifetch_cycle%0d: got ren=%b iw0=%b il0=%h, required ren=%b iw0=%b il0=%h",
                 i, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
      if (i == 3) begin
        @(posedge CLK); #1;
        iREN = 2'b00;
      end
    end
    checks++;
    if (ren_cycles != 3) begin
      errors++;
      $display("FAIL ifetch_ren_cycles: got %0d, required 3", ren_cycles);
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ifetch_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 0;
    daddr[0] = 32'h200; daddr[1] = 32'h300;
    dstore[0] = 32'h11110000; dstore[1] = 32'h22220000;
    dWEN = 2'b11;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{src: {1'b1, 1'(k % 2)}, we: 1'b1,
                     addr: (k % 2 == 0) ? 32'h200 : 32'h300,
                     data: (k % 2 == 0) ? 32'h11110000 : 32'h22220000});
    end
    wait_drain();
    dWEN = 2'b00;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
    @(negedge CLK); @(negedge CLK);
    checks++;
    if ({gnt_valid, ramWEN} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_quiet: got gv=%b wen=%b, required 0 0", gnt_valid, ramWEN);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    lat = 0;
    daddr[1] = 32'h400;
    iaddr[1] = 32'h500;
    dREN = 2'b10;
    iREN = 2'b10;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) sb.push_back('{src: 2'b01, we: 1'b0, addr: 32'h500, data: 32'h0500C0DE});
      else        sb.push_back('{src: 2'b11, we: 1'b0, addr: 32'h400, data: 32'h0400C0DE});
    end
    wait_drain();
    clear_reqs();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL starve_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_error_retry();
    do_reset();
    lat = 1;
    err_arm = 1'b1;
    daddr[0] = 32'h600;
    dstore[0] = 32'hCAFEF00D;
    dREN = 2'b01;
    dWEN = 2'b01;
    sb.push_back('{src: 2'b10, we: 1'b1, addr: 32'h600, data: 32'hCAFEF00D});
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, dwait, ram_err} !== {2'b10, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL err_grant: got wen=%b ren=%b dw=%b err=%b, required 1 0 11 0",
               ramWEN, ramREN, dwait, ram_err);
    end
    @(posedge CLK); #1;
    err_arm = 1'b0;
    checks++;
    if ({ram_err, gnt_valid, dwait} !== {1'b1, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL err_sticky: got err=%b gv=%b dw=%b, required 1 0 11", ram_err, gnt_valid, dwait);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({gnt_valid, ramWEN, dwait, ram_err} !== {2'b11, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL err_retry_busy: got gv=%b wen=%b dw=%b err=%b, required 1 1 11 1",
               gnt_valid, ramWEN, dwait, ram_err);
    end
    wait_drain();
    clear_reqs();
    checks++;
    if (sb.size() != 0 || ram_err !== 1'b1) begin
      errors++;
      $display("FAIL err_retry_done: got pending=%0d err=%b, required 0 1", sb.size(), ram_err);
    end
  endtask

  task automatic test_abort();
    do_reset();
    lat = 100;
    iaddr[1] = 32'h700;
    iREN = 2'b10;
    @(posedge CLK); #1;
    daddr[0] = 32'h800;
    dREN = 2'b01;
    @(negedge CLK);
    checks++;
    if ({gnt_valid, gnt_src, ramREN, ramaddr} !== {1'b1, 2'b01, 1'b1, 32'h700}) begin
      errors++;
      $display("FAIL abort_hold: got gv=%b src=%b ren=%b addr=%h, required 1 01 1 00000700",
               gnt_valid, gnt_src, ramREN, ramaddr);
    end
    @(posedge CLK); #1;
    iREN = 2'b00;
    lat = 0;
    sb.push_back('{src: 2'b10, we: 1'b0, addr: 32'h800, data: 32'h0800C0DE});
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait} !== {2'b00, 2'b11}) begin
      errors++;
      $display("FAIL abort_drop: got ren=%b wen=%b iw=%b, required 0 0 11", ramREN, ramWEN, iwait);
    end
    @(posedge CLK); #1;
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got gv=%b, required 0", gnt_valid);
    end
    @(posedge CLK); #1;
    checks++;
    if ({gnt_valid, gnt_src} !== 3'b110) begin
      errors++;
      $display("FAIL abort_next_grant: got gv=%b src=%b, required 1 10", gnt_valid, gnt_src);
    end
    @(posedge CLK); #1;
    clear_reqs();
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL abort_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    lat = 0; err_arm = 1'b0;
`ifdef ARB_GRANT_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_ifetch();
    test_back_to_back();
    test_starvation();
    test_error_retry();
    test_abort();
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port between four requesters: instruction fetch and data access from each of the two cores.
- Sits between the cache controllers / coherence logic and the RAM model.
- Data requests have priority; requesters of the same class are served round-robin.
- A starvation counter forces an instruction grant after a bounded run of data grants.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while an instruction request is pending before an instruction grant is forced (legal range 1..15)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  2  instruction read request, per core
- iaddr  in  2x32  instruction address (word_t), per core
- dREN  in  2  data read request, per core
- dWEN  in  2  data write request, per core
- daddr  in  2x32  data address, per core
- dstore  in  2x32  data write value, per core
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM
- ramload  in  32  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- iwait  out  2  instruction wait, per core
- dwait  out  2  data wait, per core
- iload  out  2x32  instruction return data
- dload  out  2x32  data return data
- gnt_src  out  2  current grant: {class (1=data), core}
- gnt_valid  out  1  a grant is held
- ram_err  out  1  sticky: RAM reported ERROR during a grant

Behaviour:
- Reset: state IDLE; ramREN=ramWEN=0, ramaddr=ramstore=0; iwait=dwait=2'b11; iload=dload=0; gnt_valid=0; gnt_src=0; ram_err=0; both round-robin pointers=0; starve_cnt=0.
- States: IDLE, GRANT.
- IDLE arbitration:
  - dreq[k]=dREN[k]|dWEN[k].
  - Data class is chosen if any dreq, unless any iREN is set and starve_cnt==STARVE_MAX.
  - Otherwise instruction class is chosen if any iREN.
  - Within a class: if both cores request, grant the core named by that class's pointer; otherwise grant the single requester.
  - The grant registers at the clock edge (GRANT next cycle). Nothing is driven to RAM in IDLE, so minimum latency is 1 cycle from request to ram enable.
- On grant:
  - The granted class's pointer is set to ~granted core.
  - Data grant with some iREN pending: starve_cnt++ (saturating at STARVE_MAX).
  - Data grant with no iREN pending: starve_cnt=0.
  - Instruction grant: starve_cnt=0.
- GRANT outputs (combinational from the registered grant):
  - Instruction grant: ramREN=1, ramaddr=iaddr[core].
  - Data grant: dWEN has precedence over dREN from the same core, giving ramWEN=1 and ramstore=dstore[core]; otherwise ramREN=1. ramaddr=daddr[core].
  - Non-granted waits stay 1; non-granted loads stay 0.
- Completion: a cycle in GRANT with ramstate==ACCESS deasserts the granted wait and drives ramload on the granted load port (reads). Next state IDLE. Back-to-back grants therefore cost at least 1 idle cycle.
- Abort: if the granted requester drops its request while in GRANT, ram enables drop the same cycle, wait stays 1, next state IDLE. Pointers and counter keep their updated values.
- ERROR: ramstate==ERROR in GRANT sets ram_err (cleared only by reset), keeps the wait at 1, and returns to IDLE. The requester retries by holding its request.
- FREE/BUSY in GRANT: hold the grant and keep all outputs stable.
- Asynchronous reset mid-grant: immediate return to reset values. No RAM enable may remain asserted.
- Requesters must hold address/data stable while their request is asserted. The arbiter does not latch them.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- Defined: adds output grant_cnt (4x16: i0,i1,d0,d1) counting completed (ACCESS) grants per source, saturating at 16'hFFFF, reset to 0. Also adds input stats_clr (1), which synchronously zeroes all counters; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Decomposition:
- cpu_types_pkg: word_t and ramstate_t (existing).
- Add to cpu_types_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}
  - arb_src_t packed {logic dclass; logic core;}
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin picker (inputs req[1:0], ptr; outputs valid, sel). Instantiate it once per class.

Test Plan:
- Reset with all requests held high: every wait=1, ramREN=ramWEN=0, gnt_valid=0 until the first edge after nRST rises.
- Only iREN[0]=1, iaddr[0]=0x100, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF: ramREN high 3 cycles, iwait[0]=0 and iload[0]=0xDEADBEEF in the ACCESS cycle only.
- dWEN[0] and dWEN[1] held continuously, each write taking 1 cycle: grants alternate d0,d1,d0,d1; ramstore tracks dstore of the granted core.
- STARVE_MAX=4, dREN[1] held continuously and iREN[1] raised: exactly 4 data grants, then an instruction grant for core 1, then data resumes.
- dREN[0] and dWEN[0] both set on the grant: ramWEN=1, ramREN=0. ramstate=ERROR: ram_err=1 and stays 1, dwait[0] stays 1, and the retry completes on the next ACCESS.
- Granted iREN[1] drops mid-BUSY: ramREN=0 the same cycle, IDLE next cycle, and the pending dREN[0] is granted on the following edge.
